// File: rtl/gerador_fio.sv
// Item-code generator for Itens: wrapping up/down counter behind a valid/ready handshake, luz toggles per wrap.
// Define GERADOR_SATURA_EN to saturate at the limits instead of wrapping (wrap pulses once on arrival, luz static).
module gerador_fio #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ready,
  output logic [WIDTH-1:0] fio,
  output logic             luz,
  output logic             valid,
  output logic             wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic             xfer;
  logic [WIDTH-1:0] nxt;
  logic             hit;
  logic             tog;
  logic [WIDTH-1:0] ld_clamp;

  assign xfer     = (state == RUN) && valid && ready;
  assign ld_clamp = (load_val > MAXV) ? MAXV : load_val;

  // Next code on a transfer; hit marks the cycle that produces a wrap pulse.
  always_comb begin
    nxt = fio;
    hit = 1'b0;
    tog = 1'b0;
`ifdef GERADOR_SATURA_EN
    if (dir) begin
      if (fio != MAXV) begin
        nxt = fio + ONE;
        hit = (nxt == MAXV);
      end
    end else begin
      if (fio != ZERO) begin
        nxt = fio - ONE;
        hit = (nxt == ZERO);
      end
    end
`else
    if (dir) begin
      if (fio == MAXV) begin
        nxt = ZERO;
        hit = 1'b1;
      end else begin
        nxt = fio + ONE;
      end
    end else begin
      if (fio == ZERO) begin
        nxt = MAXV;
        hit = 1'b1;
      end else begin
        nxt = fio - ONE;
      end
    end
    tog = hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      fio   <= '0;
      luz   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        // load swallows any coinciding transfer and freezes the state machine
        fio <= ld_clamp;
      end else begin
        if (xfer) begin
          fio  <= nxt;
          wrap <= hit;
          luz  <= luz ^ tog;
        end
        case (state)
          IDLE: if (en) begin
            state <= RUN;
            valid <= 1'b1;
          end
          RUN: if (!en) begin
            state <= IDLE;
            valid <= 1'b0;
          end
          default: begin
            state <= IDLE;
            valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gerador_fio.sv
// Scoreboard bench for gerador_fio: a behavioural model queues the expected outputs per cycle, compared after each edge.
module tb_gerador_fio;

  localparam int M = 63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b1, load = 1'b0, ready = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] fio;
  logic       luz, valid, wrap;

  logic       en2 = 1'b0, dir2 = 1'b1, load2 = 1'b0, ready2 = 1'b0;
  logic [6:0] load_val2 = '0;
  logic [6:0] fio2;
  logic       luz2, valid2, wrap2;

  always #5 clk = ~clk;

  gerador_fio #(.WIDTH(6), .MAX_COUNT(M)) u_dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ready(ready), .fio(fio), .luz(luz), .valid(valid), .wrap(wrap)
  );

  gerador_fio #(.WIDTH(7), .MAX_COUNT(40)) u_dut40 (
    .clk(clk), .rst(rst), .en(en2), .dir(dir2), .load(load2), .load_val(load_val2),
    .ready(ready2), .fio(fio2), .luz(luz2), .valid(valid2), .wrap(wrap2)
  );

  typedef struct {
    int fio;
    int luz;
    int valid;
    int wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  int m_fio = 0, m_luz = 0, m_valid = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one clock with the current inputs; model predicts, DUT result is popped and compared.
  task automatic cyc();
    exp_t e;
    int n_wrap;
    n_wrap = 0;
    if (rst) begin
      m_fio = 0; m_luz = 0; m_valid = 0;
    end else if (load) begin
      m_fio = (int'(load_val) > M) ? M : int'(load_val);
    end else begin
      if (m_valid == 1 && ready) begin
        if (dir) begin
          if (m_fio == M) begin
`ifdef GERADOR_SATURA_EN
            m_fio = M;
`else
            m_fio = 0; n_wrap = 1; m_luz = 1 - m_luz;
`endif
          end else begin
            m_fio = m_fio + 1;
`ifdef GERADOR_SATURA_EN
            n_wrap = (m_fio == M) ? 1 : 0;
`endif
          end
        end else begin
          if (m_fio == 0) begin
`ifdef GERADOR_SATURA_EN
            m_fio = 0;
`else
            m_fio = M; n_wrap = 1; m_luz = 1 - m_luz;
`endif
          end else begin
            m_fio = m_fio - 1;
`ifdef GERADOR_SATURA_EN
            n_wrap = (m_fio == 0) ? 1 : 0;
`endif
          end
        end
      end
      m_valid = en ? 1 : 0;
    end
    e.fio = m_fio; e.luz = m_luz; e.valid = m_valid; e.wrap = n_wrap;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("fio", int'(fio), e.fio);
    check("luz", int'(luz), e.luz);
    check("valid", int'(valid), e.valid);
    check("wrap", int'(wrap), e.wrap);
  endtask

  int wraps;

  initial begin
    // reset, also checking that rst beats a simultaneous load
    rst = 1; load = 1; load_val = 6'd33; en = 1;
    cyc();
    rst = 0; load = 0; en = 1; ready = 1; dir = 1;

    // full up sequence 0..63,0,1 with wrap and luz toggle
    wraps = 0;
    for (int i = 0; i < 66; i++) begin
      cyc();
      if (wrap) wraps++;
    end
    check("wrap_count", wraps, 1);

    // stall at 10 for five cycles
    load = 1; load_val = 6'd9; cyc(); load = 0;
    cyc();
    check("at10", int'(fio), 10);
    ready = 0;
    for (int i = 0; i < 5; i++) cyc();
    ready = 1; cyc();
    check("after_stall", int'(fio), 11);

    // down through zero
    load = 1; load_val = 6'd1; cyc(); load = 0;
    dir = 0;
    for (int i = 0; i < 3; i++) cyc();

    // load mid-run consumes the transfer
    dir = 1; load = 1; load_val = 6'd50; cyc(); load = 0;
    cyc(); cyc();

    // en drops during a transfer, then idle with load
    en = 0; cyc(); cyc();
    load = 1; load_val = 6'd62; cyc(); load = 0;
    cyc();

    // limit behaviour from 62 upward
    en = 1; cyc();
    for (int i = 0; i < 4; i++) cyc();
    dir = 0; cyc(); cyc();

    // reset at 37 with load asserted
    load = 1; load_val = 6'd37; cyc(); load = 0;
    rst = 1; load = 1; load_val = 6'd5; cyc();
    rst = 0; load = 0; cyc();

    // random mix
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      ready    = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
      load     = ($urandom_range(0, 19) == 0);
      load_val = 6'($urandom_range(0, 63));
      rst      = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0; load = 0;

    // second instance: clamp of out-of-range load, then limit step at 40
    load2 = 1; load_val2 = 7'd70; cyc(); load2 = 0;
    check("clamp70", int'(fio2), 40);
    en2 = 1; ready2 = 1; dir2 = 1; cyc();
    check("v40", int'(valid2), 1);
    cyc();
`ifdef GERADOR_SATURA_EN
    check("lim40", int'(fio2), 40);
    check("lim40_wrap", int'(wrap2), 0);
`else
    check("lim40", int'(fio2), 0);
    check("lim40_wrap", int'(wrap2), 1);
    check("lim40_luz", int'(luz2), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
